// File: rtl/write_back_stage.sv
// Write-back stage: retires register results directly and parks loads in
// WAIT_MEM until memory data returns, then writes the size/sign-extended value.
module write_back_stage #(
  parameter int DATA_WIDTH         = 32,
  parameter int GPR_WIDTH          = 3,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  result,
  input  logic [GPR_WIDTH-1:0]   destination,
  input  logic [1:0]             writeback,
  input  logic [1:0]             load_size,
  input  logic                   load_signed,
  input  logic                   mem_valid,
  input  logic [DATA_WIDTH-1:0]  mem_data,
  output logic [GPR_WIDTH-1:0]   write_address,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   write_enable,
  output logic                   pending_valid,
  output logic [GPR_WIDTH-1:0]   pending_address,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [1:0] WB_REGISTER = 2'b01;
  localparam logic [1:0] WB_MEMORY   = 2'b10;
  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;

  // Masks keep extension legal down to DATA_WIDTH=16, where the half case has no upper bits.
  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(16'hFFFF);

  state_t                  state_q, state_d;
  logic                    write_enable_q, write_enable_d;
  logic [GPR_WIDTH-1:0]    write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
  logic [GPR_WIDTH-1:0]    load_dest_q, load_dest_d;
  logic [1:0]              load_size_q, load_size_d;
  logic                    load_signed_q, load_signed_d;
  logic [COUNT_WIDTH-1:0]  retired_count_q, retired_count_d;

  logic                    wr_req;
  logic [GPR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  function automatic logic [DATA_WIDTH-1:0] extend_load(
    input logic [DATA_WIDTH-1:0] data,
    input logic [1:0]            size,
    input logic                  sign
  );
    logic [DATA_WIDTH-1:0] ext;
    case (size)
      SIZE_BYTE: begin
        ext = data & BYTE_MASK;
        if (sign && data[7]) ext = ext | ~BYTE_MASK;
      end
      SIZE_HALF: begin
        ext = data & HALF_MASK;
        if (sign && data[15]) ext = ext | ~HALF_MASK;
      end
      default: ext = data;
    endcase
    return ext;
  endfunction

  always_comb begin
    state_d         = state_q;
    write_enable_d  = 1'b0;
    write_address_d = '0;
    write_data_d    = '0;
    load_dest_d     = load_dest_q;
    load_size_d     = load_size_q;
    load_signed_d   = load_signed_q;
    retired_count_d = retired_count_q;
    wr_req          = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (writeback == WB_REGISTER) begin
            wr_req  = 1'b1;
            wr_addr = destination;
            wr_data = result;
          end else if (writeback == WB_MEMORY) begin
            state_d       = WAIT_MEM;
            load_dest_d   = destination;
            load_size_d   = load_size;
            load_signed_d = load_signed;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          state_d = IDLE;
          wr_req  = 1'b1;
          wr_addr = load_dest_q;
          wr_data = extend_load(mem_data, load_size_q, load_signed_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // A hardwired zero register swallows the write but never alters sequencing.
    if (wr_req && !(ZERO_REG_HARDWIRED != 0 && wr_addr == '0)) begin
      write_enable_d  = 1'b1;
      write_address_d = wr_addr;
      write_data_d    = wr_data;
      retired_count_d = retired_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      load_dest_q     <= '0;
      load_size_q     <= '0;
      load_signed_q   <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      load_dest_q     <= load_dest_d;
      load_size_q     <= load_size_d;
      load_signed_q   <= load_signed_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign pending_valid   = (state_q == WAIT_MEM);
  assign pending_address = pending_valid ? load_dest_q : '0;
  assign write_enable    = write_enable_q;
  assign write_address   = write_address_q;
  assign write_data      = write_data_q;
  assign retired_count   = retired_count_q;

endmodule
